// File: rtl/mod_p448_pkg.sv
// Shared definitions for arithmetic modulo the Goldilocks prime p = 2^448 - 2^224 - 1.
// Provides the field width, the prime constant, the field-element type and the
// control-state encoding used by the modular multiplier.
package mod_p448_pkg;

  localparam int N_BITS = 448;

  typedef logic [N_BITS-1:0] fe_t;

  // p = 2^448 - 2^224 - 1: upper half is 2^224 - 2, lower half is 2^224 - 1.
  localparam fe_t P448 = {{223{1'b1}}, 1'b0, {224{1'b1}}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : mod_p448_pkg

// File: rtl/mod_dbl_add_step.sv
// One MSB-first double-and-add step modulo p: acc_nxt = (2*acc + y_bit*xr) mod p.
// Latency: purely combinational.  Backpressure: none (no handshake).
// Ports: acc (< p), xr (< p), y_bit (current multiplier bit) -> acc_nxt (< p).
module mod_dbl_add_step
  import mod_p448_pkg::*;
(
  input  fe_t  acc,
  input  fe_t  xr,
  input  logic y_bit,
  output fe_t  acc_nxt
);

  localparam logic [N_BITS:0] P_EXT = {1'b0, P448};

  logic [N_BITS:0] dbl;
  logic [N_BITS:0] dbl_red;
  logic [N_BITS:0] sum;
  logic [N_BITS:0] sum_red;

  // Both inputs are < p, so each partial value is < 2p and a single
  // conditional subtraction brings it back into range.
  always_comb begin
    dbl     = {acc, 1'b0};
    dbl_red = (dbl >= P_EXT) ? (dbl - P_EXT) : dbl;
    sum     = dbl_red + (y_bit ? {1'b0, xr} : '0);
    sum_red = (sum >= P_EXT) ? (sum - P_EXT) : sum;
    acc_nxt = sum_red[N_BITS-1:0];
  end

endmodule : mod_dbl_add_step

// File: rtl/mult_mod.sv
// Sequential modular multiplier Z = X*Y mod (2^448 - 2^224 - 1), MSB-first double-and-add.
// Latency: 448 edges accept-to-res_valid (224 with MULT_MOD_RADIX4_EN defined, two bits per cycle).
// Backpressure: result held in DONE until res_ready; req_ready low unless idle.
// Ports: clk, rst (async, active-high); X, Y, req_valid -> req_ready, req_busy;
//        Z, res_valid -> res_ready.  Optional build macro: MULT_MOD_RADIX4_EN.
module mult_mod
  import mod_p448_pkg::*;
#(
  parameter int N = N_BITS
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] X,
  input  logic [N-1:0] Y,
  input  logic         req_valid,
  output logic         req_ready,
  output logic         req_busy,
  output logic [N-1:0] Z,
  output logic         res_valid,
  input  logic         res_ready
);

`ifdef MULT_MOD_RADIX4_EN
  localparam logic [8:0] STEP = 9'd2;
`else
  localparam logic [8:0] STEP = 9'd1;
`endif

  state_t     state_q;
  state_t     state_d;
  fe_t        xr;
  fe_t        yr;   // shifted left each cycle so the current bit is always at the MSB
  fe_t        acc;
  fe_t        z_q;
  logic [8:0] cnt;
  fe_t        step_out;
  logic       last;

  // ---------------------------------------------------------------------------
  // Datapath: one or two chained double/add/reduce steps per RUN cycle
  // ---------------------------------------------------------------------------
  fe_t step1_out;

  mod_dbl_add_step u_step1 (
    .acc     (acc),
    .xr      (xr),
    .y_bit   (yr[N_BITS-1]),
    .acc_nxt (step1_out)
  );

`ifdef MULT_MOD_RADIX4_EN
  fe_t step2_out;

  mod_dbl_add_step u_step2 (
    .acc     (step1_out),
    .xr      (xr),
    .y_bit   (yr[N_BITS-2]),
    .acc_nxt (step2_out)
  );

  assign step_out = step2_out;
`else
  assign step_out = step1_out;
`endif

  // cnt holds the index of the highest bit still to be processed.
  assign last = (cnt < STEP);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (req_valid) state_d = RUN;
      RUN:     if (last)      state_d = DONE;
      DONE:    if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Operand, accumulator and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr  <= '0;
      yr  <= '0;
      acc <= '0;
      cnt <= '0;
      z_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid) begin
            // X < 2^448 < 2p, so one subtraction fully reduces it.
            xr  <= (X >= P448) ? (X - P448) : X;
            yr  <= Y;
            acc <= '0;
            cnt <= 9'(N_BITS - 1);
          end
        end
        RUN: begin
          acc <= step_out;
          yr  <= yr << STEP;
          if (last) begin
            z_q <= step_out;
            cnt <= '0;
          end else begin
            cnt <= cnt - STEP;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: pure decodes of registered state
  // ---------------------------------------------------------------------------
  assign req_ready = (state_q == IDLE);
  assign req_busy  = (state_q == RUN);
  assign res_valid = (state_q == DONE);
  assign Z         = z_q;

endmodule : mult_mod

// File: tb/tb_mult_mod.sv
// Self-checking bench for mult_mod: directed vectors, randomized operands against
// a wide-integer reference (X*Y mod p), back-pressure, streaming and mid-run reset.
module tb_mult_mod;

  typedef logic [447:0] fe_t;

  localparam logic [448:0] P_W = (449'd1 << 448) - (449'd1 << 224) - 449'd1;
  localparam fe_t P = P_W[447:0];

`ifdef MULT_MOD_RADIX4_EN
  localparam int LAT = 224;
`else
  localparam int LAT = 448;
`endif

  logic clk = 1'b0;
  logic rst;
  fe_t  X;
  fe_t  Y;
  logic req_valid;
  logic req_ready;
  logic req_busy;
  fe_t  Z;
  logic res_valid;
  logic res_ready;

  int checks = 0;
  int errors = 0;

  mult_mod #(.N(448)) dut (
    .clk       (clk),
    .rst       (rst),
    .X         (X),
    .Y         (Y),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_busy  (req_busy),
    .Z         (Z),
    .res_valid (res_valid),
    .res_ready (res_ready)
  );

  always #5 clk = ~clk;

  // Reference: exact integer product reduced modulo p.
  function automatic fe_t ref_mul(input fe_t a, input fe_t b);
    logic [895:0] prod;
    logic [895:0] modv;
    prod = {448'd0, a} * {448'd0, b};
    modv = prod % {448'd0, P};
    return modv[447:0];
  endfunction

  function automatic fe_t rand_fe();
    fe_t r;
    for (int i = 0; i < 14; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic check(input string tag, input fe_t obs, input fe_t exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one request and wait for the result; returns Z and accept-to-valid latency.
  task automatic run_mult(input fe_t a, input fe_t b, output fe_t zres, output int lat);
    @(negedge clk);
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    check("req_ready_before_accept", fe_t'(req_ready), 448'd1);
    X = a;
    Y = b;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    X = rand_fe();          // operands may change freely once accepted
    Y = rand_fe();
    check("busy_after_accept", fe_t'({req_busy, req_ready}), 448'd2);
    lat = 0;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk);
      #1;
      lat++;
      if (res_valid) break;
    end
    check("res_valid_rise", fe_t'(res_valid), 448'd1);
    zres = Z;
  endtask

  task automatic consume(input string tag);
    res_ready = 1'b1;
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    check(tag, fe_t'({res_valid, req_ready, req_busy}), 448'b010);
  endtask

  fe_t cx [4];
  fe_t cy [4];
  fe_t cz [4];

  initial begin
    fe_t zr;
    fe_t a;
    fe_t b;
    fe_t held;
    int  lat;
    int  cyc;
    int  prev;

    rst       = 1'b1;
    X         = '0;
    Y         = '0;
    req_valid = 1'b0;
    res_ready = 1'b0;
    #1;
    check("reset_ready", fe_t'(req_ready), 448'd1);
    check("reset_busy", fe_t'(req_busy), 448'd0);
    check("reset_valid", fe_t'(res_valid), 448'd0);
    check("reset_z", Z, 448'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Reference vector with exact latency
    run_mult(448'd484559149530404593699549205258669689569094240458212040187660132787056912146709081364401144455726350866276831544947397859048262938744149,
             448'd628930339897224761877458712630456916313059351224950674660715238218025224359569994148177859636458751997369808394808543907584068268720738,
             zr, lat);
    check("vec_latency", fe_t'(lat), fe_t'(LAT));
    check("vec_z", zr, 448'd387304051755042505631669743731884414390525906745274713463103348481248176085515023438354995513075395833444908195326698307529995922079670);
    consume("vec_consume");

    // Boundary vectors with hand-derived results
    cx[0] = P - 448'd1;  cy[0] = P - 448'd1;  cz[0] = 448'd1;
    cx[1] = 448'd0;      cy[1] = 448'd12345;  cz[1] = 448'd0;
    cx[2] = 448'd1;      cy[2] = P - 448'd1;  cz[2] = P - 448'd1;
    cx[3] = '1;          cy[3] = 448'd1;      cz[3] = 448'd1 << 224;
    for (int k = 0; k < 4; k++) begin
      run_mult(cx[k], cy[k], zr, lat);
      check($sformatf("corner%0d_z", k), zr, cz[k]);
      check($sformatf("corner%0d_lat", k), fe_t'(lat), fe_t'(LAT));
      consume($sformatf("corner%0d_consume", k));
    end

    // Randomized operands, including unreduced X and all-ones Y
    for (int k = 0; k < 6; k++) begin
      a = rand_fe();
      b = rand_fe();
      if (k == 1) a = P + fe_t'($urandom);
      if (k == 2) b = '1;
      run_mult(a, b, zr, lat);
      check($sformatf("rand%0d_z", k), zr, ref_mul(a, b));
      consume($sformatf("rand%0d_consume", k));
    end

    // Back-pressure: DONE holds; req_valid ignored while not idle
    a = rand_fe();
    b = rand_fe();
    run_mult(a, b, zr, lat);
    check("bp_z", zr, ref_mul(a, b));
    held = Z;
    req_valid = 1'b1;
    X = rand_fe();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp_hold%0d", i), fe_t'({res_valid, req_ready}), 448'b10);
      check($sformatf("bp_zstable%0d", i), Z, held);
    end
    req_valid = 1'b0;
    consume("bp_consume");
    repeat (3) @(posedge clk);
    #1;
    check("z_kept_after_consume", Z, held);

    // Streaming: req_valid held high, consumer acks one cycle after res_valid
    a = rand_fe();
    b = rand_fe();
    @(negedge clk);
    X = a;
    Y = b;
    req_valid = 1'b1;
    cyc = 0;
    prev = 0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 1000; i++) begin
        @(posedge clk);
        #1;
        cyc++;
        if (res_valid) break;
      end
      check($sformatf("stream%0d_valid", k), fe_t'(res_valid), 448'd1);
      check($sformatf("stream%0d_z", k), Z, ref_mul(a, b));
      if (k > 0) check($sformatf("stream%0d_gap_ok", k), fe_t'(cyc - prev >= LAT + 2), 448'd1);
      prev = cyc;
      @(posedge clk);
      #1;
      cyc++;
      res_ready = 1'b1;
      @(posedge clk);
      #1;
      cyc++;
      res_ready = 1'b0;
      a = rand_fe();
      b = rand_fe();
      X = a;
      Y = b;
      if (k == 2) req_valid = 1'b0;
    end

    // Reset in the middle of a computation
    @(negedge clk);
    X = rand_fe();
    Y = rand_fe();
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (100) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_state", fe_t'({req_ready, req_busy, res_valid}), 448'b100);
    check("midrst_z", Z, 448'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (LAT + 10) @(posedge clk);
    #1;
    check("midrst_no_result", fe_t'({req_ready, res_valid}), 448'b10);
    a = rand_fe();
    b = rand_fe();
    run_mult(a, b, zr, lat);
    check("after_rst_z", zr, ref_mul(a, b));
    check("after_rst_lat", fe_t'(lat), fe_t'(LAT));
    consume("after_rst_consume");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_mult_mod
